// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I immediate generator with 2-entry skid buffer (optional IMM_GEN_ZICSR_EN)
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ill_cnt,
    input  logic             ill_clr
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z   = 3'd6;
`endif
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_skid_to_main;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm_ext;
    logic [2:0]        w_fmt;

    logic [XLEN-1:0]   r_main_imm;
    logic [2:0]        r_main_fmt;
    logic [TAG_W-1:0]  r_main_tag;
    logic [XLEN-1:0]   r_skid_imm;
    logic [2:0]        r_skid_fmt;
    logic [TAG_W-1:0]  r_skid_tag;
    logic [CNT_W-1:0]  r_ill_cnt;

    assign in_ready   = (r_state != S_TWO);
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign out_imm    = r_main_imm;
    assign out_fmt    = r_main_fmt;
    assign out_tag    = r_main_tag;
    assign ill_cnt    = r_ill_cnt;

    // Decode the format from the opcode and assemble the 32-bit immediate
    always_comb begin
        w_imm32 = 32'd0;
        w_fmt   = FMT_ILL;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:2])
                5'b00100, 5'b00000, 5'b11001, 5'b00011: begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                5'b11100: begin
`ifdef IMM_GEN_ZICSR_EN
                    if (in_instr[14:12] != 3'b000) begin
                        w_fmt   = FMT_Z;
                        w_imm32 = {27'd0, in_instr[19:15]};
                    end else begin
                        w_fmt   = FMT_I;
                        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    end
`else
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
                end
                5'b01000: begin
                    w_fmt   = FMT_S;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                5'b11000: begin
                    w_fmt   = FMT_B;
                    w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
                end
                5'b01101, 5'b00101: begin
                    w_fmt   = FMT_U;
                    w_imm32 = {in_instr[31:12], 12'd0};
                end
                5'b11011: begin
                    w_fmt   = FMT_J;
                    w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
                end
                5'b01100: begin
                    w_fmt   = FMT_R;
                    w_imm32 = 32'd0;
                end
                default: begin
                    w_fmt   = FMT_ILL;
                    w_imm32 = 32'd0;
                end
            endcase
        end
    end

    // Widen to XLEN; the zimm case has bit 31 clear so it stays zero-extended
    always_comb begin
        w_imm_ext        = {XLEN{w_imm32[31]}};
        w_imm_ext[31:0]  = w_imm32;
    end

    // Skid buffer occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and which stage to load from the decoder or the skid entry
    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_skid_to_main = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Main (output) stage: fresh decode or the older skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_imm <= '0;
            r_main_fmt <= 3'd0;
            r_main_tag <= '0;
        end else if (w_load_main) begin
            r_main_imm <= w_imm_ext;
            r_main_fmt <= w_fmt;
            r_main_tag <= in_tag;
        end else if (w_skid_to_main) begin
            r_main_imm <= r_skid_imm;
            r_main_fmt <= r_skid_fmt;
            r_main_tag <= r_skid_tag;
        end
    end

    // Skid stage catches the instruction accepted while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_imm <= '0;
            r_skid_fmt <= 3'd0;
            r_skid_tag <= '0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_imm_ext;
            r_skid_fmt <= w_fmt;
            r_skid_tag <= in_tag;
        end
    end

    // Saturating count of accepted illegal instructions; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (ill_clr) begin
            r_ill_cnt <= '0;
        end else if (w_in_fire && (w_fmt == FMT_ILL) && (r_ill_cnt != {CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] ill_cnt;
    logic             ill_clr;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    int               exp_cnt  = 0;
    logic             last_fired = 1'b0;
    logic             p_valid = 1'b0, p_ready = 1'b0, p_in_fire = 1'b0, p_empty = 1'b1;
    logic [XLEN-1:0]  p_imm = '0;
    logic [2:0]       p_fmt = '0;
    logic [TAG_W-1:0] p_tag = '0;
    int               waits;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_tag(out_tag), .ill_cnt(ill_cnt), .ill_clr(ill_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.imm = imm[XLEN-1:0];
        e.fmt = fmt;
        e.tag = tag;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [TAG_W-1:0] tag);
        logic signed [31:0] v;
        logic [2:0]         f;
        v = 0;
        f = 3'd7;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F: begin f = 3'd1; v = $signed(i[31:20]); end
            7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                if (i[14:12] != 3'd0) begin f = 3'd6; v = {27'd0, i[19:15]}; end
                else begin f = 3'd1; v = $signed(i[31:20]); end
`else
                f = 3'd1; v = $signed(i[31:20]);
`endif
            end
            7'h23: begin f = 3'd2; v = $signed({i[31:25], i[11:7]}); end
            7'h63: begin f = 3'd3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'h37, 7'h17: begin f = 3'd4; v = {i[31:12], 12'd0}; end
            7'h6F: begin f = 3'd5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            7'h33: begin f = 3'd0; v = 0; end
            default: begin f = 3'd7; v = 0; end
        endcase
        return mk({{32{v[31]}}, v}, f, tag);
    endfunction

    // One cycle: check what the last edge produced, drive inputs, predict the next edge
    task automatic step(input logic v, input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                        input exp_t e, input logic ordy, input logic clr);
        exp_t got;
        @(negedge clk);
        if (p_in_fire && p_empty) check("latency_valid", out_valid, 1);
        if (p_valid && !p_ready) begin
            check("stable_valid", out_valid, 1);
            check("stable_imm", out_imm, p_imm);
            check("stable_fmt", out_fmt, p_fmt);
            check("stable_tag", out_tag, p_tag);
        end
        check("ill_cnt", ill_cnt, exp_cnt);
        in_valid  = v;
        in_instr  = instr;
        in_tag    = tag;
        out_ready = ordy;
        ill_clr   = clr;
        last_fired = v && in_ready;
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                check("out_without_input", out_valid, 0);
            end else begin
                got = sb.pop_front();
                check("out_imm", out_imm, got.imm);
                check("out_fmt", out_fmt, got.fmt);
                check("out_tag", out_tag, got.tag);
            end
        end
        if (last_fired) sb.push_back(e);
        if (clr) exp_cnt = 0;
        else if (last_fired && e.fmt == 3'd7 && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        p_valid   = out_valid;
        p_ready   = ordy;
        p_imm     = out_imm;
        p_fmt     = out_fmt;
        p_tag     = out_tag;
        p_in_fire = last_fired;
        p_empty   = !out_valid;
    endtask

    task automatic send(input logic [31:0] instr, input logic [TAG_W-1:0] tag, input exp_t e,
                        input logic ordy, input logic clr, output int n);
        n = 0;
        do begin
            step(1'b1, instr, tag, e, ordy, clr);
            n++;
        end while (!last_fired && n < 50);
        check("send_accept", last_fired, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            step(1'b0, 32'd0, '0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] ri;
        logic [6:0]  ops [0:9];
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33, 7'h2B};
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0; ill_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_fmt", out_fmt, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_ill_cnt", ill_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // addi -1
        send(32'hFFF00093, 8'h05, mk(64'hFFFFFFFF, 3'd1, 8'h05), 1'b1, 1'b0, waits);
        drain();

        // back-to-back S, B, U at full throughput
        send(32'hFE20AE23, 8'h10, mk(64'hFFFFFFFC, 3'd2, 8'h10), 1'b1, 1'b0, waits);
        check("b2b_wait0", waits, 1);
        send(32'hFE000EE3, 8'h11, mk(64'hFFFFFFFC, 3'd3, 8'h11), 1'b1, 1'b0, waits);
        check("b2b_wait1", waits, 1);
        send(32'h123450B7, 8'h12, mk(64'h12345000, 3'd4, 8'h12), 1'b1, 1'b0, waits);
        check("b2b_wait2", waits, 1);
        send(32'h002081B3, 8'h13, mk(64'h0, 3'd0, 8'h13), 1'b1, 1'b0, waits);
        send(32'h0080006F, 8'h14, mk(64'h8, 3'd5, 8'h14), 1'b1, 1'b0, waits);
        drain();

        // stall: fill both stages, third instruction must wait
        send(32'hFFF00093, 8'd1, mk(64'hFFFFFFFF, 3'd1, 8'd1), 1'b0, 1'b0, waits);
        send(32'h00500113, 8'd2, mk(64'h5, 3'd1, 8'd2), 1'b0, 1'b0, waits);
        step(1'b1, 32'h0080006F, 8'd3, mk(64'h8, 3'd5, 8'd3), 1'b0, 1'b0);
        check("stall_in_ready", in_ready, 0);
        repeat (3) step(1'b1, 32'h0080006F, 8'd3, mk(64'h8, 3'd5, 8'd3), 1'b0, 1'b0);
        send(32'h0080006F, 8'd3, mk(64'h8, 3'd5, 8'd3), 1'b1, 1'b0, waits);
        check("stall_resume_wait", waits, 2);
        drain();

        // illegal instructions and counter saturation
        step(1'b0, 32'd0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            send((k % 2) ? 32'h0000007F : 32'h00000000, TAG_W'(8'h20 + k),
                 mk(64'h0, 3'd7, TAG_W'(8'h20 + k)), 1'b1, 1'b0, waits);
        end
        step(1'b0, 32'd0, '0, '0, 1'b1, 1'b0);
        check("ill_saturated", ill_cnt, 3);
        step(1'b1, 32'h00000000, 8'h30, mk(64'h0, 3'd7, 8'h30), 1'b1, 1'b1);
        step(1'b0, 32'd0, '0, '0, 1'b1, 1'b0);
        check("ill_clr_prio", ill_cnt, 0);
        drain();

        // CSR immediate
`ifdef IMM_GEN_ZICSR_EN
        send(32'h3002D073, 8'h31, mk(64'h5, 3'd6, 8'h31), 1'b1, 1'b0, waits);
`else
        send(32'h3002D073, 8'h31, mk(64'h300, 3'd1, 8'h31), 1'b1, 1'b0, waits);
`endif
        drain();

        // random traffic with random backpressure
        for (int k = 0; k < 60; k++) begin
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) ri[1:0] = 2'($urandom_range(0, 2));
            step(1'($urandom_range(0, 3) != 0), ri, TAG_W'(k), model(ri, TAG_W'(k)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        drain();

        // asynchronous reset while both stages are full
        step(1'b0, 32'd0, '0, '0, 1'b1, 1'b1);
        send(32'h00000000, 8'h40, mk(64'h0, 3'd7, 8'h40), 1'b0, 1'b0, waits);
        send(32'hFFF00093, 8'h41, mk(64'hFFFFFFFF, 3'd1, 8'h41), 1'b0, 1'b0, waits);
        @(posedge clk);
        #2;
        check("pre_rst_in_ready", in_ready, 0);
        check("pre_rst_ill_cnt", ill_cnt, 1);
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_ill_cnt", ill_cnt, 0);
        check("async_out_imm", out_imm, 0);
        repeat (2) @(posedge clk);
        #1;
        check("in_rst_out_valid", out_valid, 0);
        check("in_rst_ill_cnt", ill_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        exp_cnt = 0;
        p_valid = 1'b0; p_ready = 1'b0; p_in_fire = 1'b0; p_empty = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        send(32'h123450B7, 8'h50, mk(64'h12345000, 3'd4, 8'h50), 1'b1, 1'b0, waits);
        check("post_rst_wait", waits, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the next-generation (pipelined) core.
- Accepts a full 32-bit instruction word and decodes the format from the opcode.
- Covers all RV32I immediate formats (I/S/B/U/J plus R), sign-extends to XLEN, and reports format code and illegal flag.
- Sits between fetch/decode and execute behind a valid/ready handshake, with a 2-entry skid buffer and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills bits XLEN-1 down to 32 when 64.
- TAG_W, 8, width of the sideband tag (PC index / ROB id) carried alongside each instruction.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  block can accept; equals NOT skid_valid
- in_instr  in  32  raw instruction word
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  generated immediate
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, Z=6, ILL=7
- out_tag  out  TAG_W  tag of out_imm
- ill_cnt  out  CNT_W  accepted illegal instructions, saturating
- ill_clr  in  1  synchronous clear of ill_cnt

Behaviour:
- Interface: one clock, reset asynchronous and active-low. Clock port is clk; reset port is rst_n.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_tag=0, ill_cnt=0, skid empty. in_ready=1 once reset is released.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency is 1 cycle: result registered at the clock edge that accepts the instruction. Throughput is 1/cycle while out_ready=1.
- Decode is on instr[6:2]; instr[1:0] must be 2'b11, otherwise ILL.
  - 00100 OP-IMM, 00000 LOAD, 11001 JALR, 00011 MISC-MEM, 11100 SYSTEM: fmt I, imm = sext(instr[31:20]).
  - 01000 STORE: fmt S, imm = sext({instr[31:25], instr[11:7]}).
  - 11000 BRANCH: fmt B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 01101 LUI, 00101 AUIPC: fmt U, imm = sext({instr[31:12], 12'b0}).
  - 11011 JAL: fmt J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 01100 OP: fmt R, imm = 0.
  - Any other opcode: fmt ILL, imm = 0.
- Skid buffer states: EMPTY (out_valid=0), ONE (main register valid), TWO (main and skid valid).
  - EMPTY + in_fire -> ONE; main loaded.
  - ONE + in_fire + out_fire -> ONE; main reloaded.
  - ONE + in_fire, no out_fire -> TWO; skid loaded.
  - ONE + out_fire, no in_fire -> EMPTY.
  - TWO + out_fire -> ONE; skid moves to main. in_ready=0 in TWO, so no accept.
  - TWO, no out_fire -> hold.
- Output stability: out_imm/out_fmt/out_tag stay stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO order; no drops, no duplicates.
- ill_cnt increments on in_fire of an ILL instruction and saturates at 2^CNT_W-1.
  - ill_clr has priority: clear and increment in the same cycle -> 0.
- Reset mid-operation: both stages flushed and the counter cleared immediately (asynchronous); in-flight data is lost.
- Inputs while rst_n=0 are ignored.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN
- Defined: SYSTEM opcode with funct3 != 000 gives fmt Z, imm = zero-extended instr[19:15] (CSR zimm). funct3 = 000 (ECALL/EBREAK) stays fmt I.
- Undefined: all SYSTEM instructions are fmt I, imm = sext(instr[31:20]). Format code 6 never produced.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1. With XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- Back-to-back 0xFE20AE23 (sw), 0xFE000EE3 (beq -4), 0x123450B7 (lui) -> consecutive cycles give imm 0xFFFFFFFC/fmt 2, 0xFFFFFFFC/fmt 3, 0x12345000/fmt 4; tags preserved.
- out_ready=0, push tags 1,2 -> in_ready=0 after the second accept; tag 3 held. Raise out_ready -> outputs 1,2,3 in order, none lost, outputs stable while stalled.
- 0x00000000 and 0x0000007F with CNT_W=2, six illegal pushes -> each fmt=7, imm=0; ill_cnt saturates at 3. ill_clr together with an illegal push -> 0.
- 0x3002D073 (csrrwi x0,0x300,5) -> with IMM_GEN_ZICSR_EN: imm=0x00000005, fmt=6. Without: imm=0x00000300, fmt=1.
- Assert rst_n low while in state TWO -> out_valid=0 and ill_cnt=0 immediately without a clock edge. After release in_ready=1 and the first new instruction appears 1 cycle after accept.
